// File: rtl/stepper_move_sequencer.sv
// Trapezoidal step-train sequencer for a 2-phase stepper driver: one move at a time, linear ramp, hold-current timeout.
// Optional STEPPER_POSITION_EN adds a signed step position counter with synchronous clear.
module stepper_move_sequencer #(
  parameter int CNT_W        = 24,
  parameter int STEP_W       = 16,
  parameter int START_PERIOD = 1000,
  parameter int RAMP_DEC     = 100,
  parameter int PULSE_CYC    = 10,
  parameter int SETUP_CYC    = 20,
  parameter int HOLD_CYC     = 5000,
  parameter int RUN_VREF     = 15,
  parameter int HOLD_VREF    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              step_pulse,
  output logic              dir,
  output logic              motor_en,
  output logic [3:0]        vref_level,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_left
`ifdef STEPPER_POSITION_EN
  ,
  output logic signed [31:0] position,
  input  logic               pos_clear
`endif
);

  localparam logic [CNT_W-1:0] L_START      = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] L_MIN_PERIOD = CNT_W'(2 * PULSE_CYC);
  localparam logic [CNT_W-1:0] L_PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] L_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_RAMP_N     = CNT_W'(RAMP_DEC);
  localparam logic [CNT_W:0]   L_RAMP_W     = (CNT_W + 1)'(RAMP_DEC);
  localparam logic [3:0]       L_RUN_VREF   = 4'(RUN_VREF);
  localparam logic [3:0]       L_HOLD_VREF  = 4'(HOLD_VREF);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_HOLD} state_t;

  state_t            r_state, w_stateNext;
  logic [CNT_W-1:0]  r_cnt, r_cur, r_target;
  logic [STEP_W-1:0] r_stepsLeft, r_acc;
  logic              r_dir, r_stepPulse, r_motorEn, r_done, r_aborted, r_abortReq;
  logic [3:0]        r_vref;

  logic              w_accept, w_acceptMove, w_abortSeen;
  logic              w_setupEnd, w_periodEnd, w_holdEnd, w_issue, w_moveEnd;
  logic              w_decel, w_accInc;
  logic [CNT_W-1:0]  w_cmdTarget, w_cmdCur, w_upSat, w_downSat, w_nextCur;
  logic [CNT_W:0]    w_up, w_targetPlusRamp;

  assign cmd_ready    = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign busy         = (r_state == S_SETUP) || (r_state == S_RUN);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_acceptMove = w_accept && (cmd_steps != '0);
  assign w_abortSeen  = r_abortReq || abort;
  assign w_setupEnd   = (r_state == S_SETUP) && (r_cnt == L_SETUP_LAST);
  assign w_periodEnd  = (r_state == S_RUN) && (r_cnt == (r_cur - CNT_W'(1)));
  assign w_holdEnd    = (r_state == S_HOLD) && (r_cnt == L_HOLD_LAST);
  assign w_issue      = (w_setupEnd || (w_periodEnd && (r_stepsLeft != '0))) && !w_abortSeen;
  assign w_moveEnd    = (w_setupEnd && w_abortSeen) ||
                        (w_periodEnd && (w_abortSeen || (r_stepsLeft == '0)));

  assign step_pulse = r_stepPulse;
  assign dir        = r_dir;
  assign motor_en   = r_motorEn;
  assign vref_level = r_vref;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign steps_left = r_stepsLeft;

  // Command conditioning and next-period selection; deceleration wins once the
  // remaining steps no longer cover the steps spent accelerating.
  always_comb begin
    w_cmdTarget      = (cmd_period > L_MIN_PERIOD) ? cmd_period : L_MIN_PERIOD;
    w_cmdCur         = (w_cmdTarget > L_START) ? w_cmdTarget : L_START;
    w_up             = {1'b0, r_cur} + L_RAMP_W;
    w_upSat          = (w_up > {1'b0, L_START}) ? L_START : w_up[CNT_W-1:0];
    w_targetPlusRamp = {1'b0, r_target} + L_RAMP_W;
    w_downSat        = ({1'b0, r_cur} > w_targetPlusRamp) ? (r_cur - L_RAMP_N) : r_target;
    w_decel          = (r_stepsLeft <= r_acc);
    w_nextCur        = r_cur;
    if (w_decel) begin
      w_nextCur = w_upSat;
    end else if (r_cur > r_target) begin
      w_nextCur = w_downSat;
    end
    w_accInc = !w_decel && (w_nextCur > r_target) && (r_acc != '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_acceptMove) w_stateNext = S_SETUP;
      S_SETUP: if (w_setupEnd) w_stateNext = w_moveEnd ? S_HOLD : S_RUN;
      S_RUN:   if (w_moveEnd) w_stateNext = S_HOLD;
      S_HOLD: begin
        if (w_acceptMove) begin
          w_stateNext = S_SETUP;
        end else if (w_holdEnd) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // One shared counter times the setup window, each step period and the hold window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_cur       <= '0;
      r_target    <= '0;
      r_stepsLeft <= '0;
      r_acc       <= '0;
      r_dir       <= 1'b0;
      r_stepPulse <= 1'b0;
      r_motorEn   <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_abortReq  <= 1'b0;
      r_vref      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (w_accept && (cmd_steps == '0)) begin
        r_done <= 1'b1;
      end
      if (w_acceptMove) begin
        r_dir       <= cmd_dir;
        r_stepsLeft <= cmd_steps;
        r_target    <= w_cmdTarget;
        r_cur       <= w_cmdCur;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_abortReq  <= 1'b0;
        r_motorEn   <= 1'b1;
        r_vref      <= L_RUN_VREF;
      end else begin
        case (r_state)
          S_SETUP, S_RUN: begin
            if (abort) begin
              r_abortReq <= 1'b1;
            end
            if (w_issue) begin
              r_cnt       <= '0;
              r_stepPulse <= 1'b1;
              r_stepsLeft <= r_stepsLeft - STEP_W'(1);
              if (r_state == S_SETUP) begin
                r_acc <= (r_cur > r_target) ? STEP_W'(1) : '0;
              end else begin
                r_cur <= w_nextCur;
                r_acc <= r_acc + STEP_W'(w_accInc);
              end
            end else if (w_moveEnd) begin
              r_cnt      <= '0;
              r_done     <= 1'b1;
              r_aborted  <= w_abortSeen && (r_stepsLeft != '0);
              r_vref     <= L_HOLD_VREF;
              r_abortReq <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if ((r_state == S_RUN) && (r_cnt == L_PULSE_LAST)) begin
                r_stepPulse <= 1'b0;
              end
            end
          end
          S_HOLD: begin
            if (w_holdEnd) begin
              r_cnt     <= '0;
              r_motorEn <= 1'b0;
              r_vref    <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STEPPER_POSITION_EN
  // A clear on the same cycle as a step edge discards that step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position <= '0;
    end else if (pos_clear) begin
      position <= '0;
    end else if (w_issue) begin
      position <= r_dir ? (position + 32'sd1) : (position - 32'sd1);
    end
  end
`endif

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed self-checking bench for stepper_move_sequencer (default parameters).
module tb_stepper_move_sequencer;
  localparam int CNT_W  = 24;
  localparam int STEP_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic [CNT_W-1:0]  cmd_period;
  logic              abort;
  logic              step_pulse;
  logic              dir;
  logic              motor_en;
  logic [3:0]        vref_level;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_left;
`ifdef STEPPER_POSITION_EN
  logic signed [31:0] position;
  logic               pos_clear;
`endif

  stepper_move_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period), .abort(abort),
    .step_pulse(step_pulse), .dir(dir), .motor_en(motor_en), .vref_level(vref_level),
    .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
`ifdef STEPPER_POSITION_EN
    , .position(position), .pos_clear(pos_clear)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Edge recorder: cycle numbers are the cyc value seen at the falling edge.
  int riseQ[$];
  int widthQ[$];
  int enFalls = 0;
  int pulseStart = 0;
  logic prevPulse = 1'b0;
  logic prevEn = 1'b0;
  always @(negedge clk) begin
    if (step_pulse && !prevPulse) begin
      riseQ.push_back(cyc);
      pulseStart <= cyc;
    end
    if (!step_pulse && prevPulse) widthQ.push_back(cyc - pulseStart);
    if (!motor_en && prevEn) enFalls <= enFalls + 1;
    prevPulse <= step_pulse;
    prevEn    <= motor_en;
  end

  task automatic clear_q;
    riseQ.delete();
    widthQ.delete();
  endtask

  task automatic send_cmd(input int steps, input bit d, input int per, output int t, output bit ok);
    int k;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_steps  = steps[STEP_W-1:0];
    cmd_dir    = d;
    cmd_period = per[CNT_W-1:0];
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = cmd_ready;
    t  = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = done;
  endtask

  task automatic wait_en_low(input int budget, output bit ok);
    int k;
    k = 0;
    while (motor_en && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = !motor_en;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({step_pulse, dir, motor_en, busy, done, aborted} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {step_pulse, dir, motor_en, busy, done, aborted});
    end
    checks++;
    if (vref_level !== 4'd0 || steps_left !== '0) begin
      errors++;
      $display("[TB] FAIL reset_levels: vref %0d steps_left %0d expected 0 0", vref_level, steps_left);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_three_steps;
    int t;
    bit ok;
    int dc;
    clear_q();
    send_cmd(3, 1'b1, 1000, t, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL three_accept: got 0 expected 1"); end
    checks++;
    if ({busy, motor_en, dir} !== 3'b111 || vref_level !== 4'd15) begin
      errors++;
      $display("[TB] FAIL three_setup: busy/en/dir %b vref %0d expected 111 15", {busy, motor_en, dir}, vref_level);
    end
    wait_done(4000, ok);
    dc = cyc;
    checks++;
    if (!ok || dc != t + 3021) begin
      errors++;
      $display("[TB] FAIL three_done: got cycle %0d expected %0d", dc - t, 3021);
    end
    checks++;
    if (aborted !== 1'b0 || vref_level !== 4'd4 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL three_hold: aborted %b vref %0d busy %b expected 0 4 0", aborted, vref_level, busy);
    end
    checks++;
    if (riseQ.size() != 3) begin
      errors++;
      $display("[TB] FAIL three_count: got %0d expected 3", riseQ.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (riseQ[i] != t + 21 + 1000 * i) begin
          errors++;
          $display("[TB] FAIL three_rise%0d: got %0d expected %0d", i, riseQ[i] - t, 21 + 1000 * i);
        end
      end
    end
    checks++;
    if (widthQ.size() != 3 || widthQ[0] != 10 || widthQ[1] != 10 || widthQ[2] != 10) begin
      errors++;
      $display("[TB] FAIL three_width: got count %0d first %0d expected 3 x 10", widthQ.size(),
               (widthQ.size() > 0) ? widthQ[0] : -1);
    end
    wait_en_low(6000, ok);
    checks++;
    if (!ok || cyc != t + 8021 || vref_level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL three_en_off: got cycle %0d vref %0d expected 8021 0", cyc - t, vref_level);
    end
`ifdef STEPPER_POSITION_EN
    checks++;
    if (position !== 32'sd3) begin errors++; $display("[TB] FAIL three_pos: got %0d expected 3", position); end
`endif
  endtask

  task automatic test_zero_steps;
    int t;
    bit ok;
    int doneCount;
    int enSeen;
    clear_q();
    send_cmd(0, 1'b0, 500, t, ok);
    checks++;
    if (!ok || done !== 1'b1 || aborted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done: done %b aborted %b expected 1 0", done, aborted);
    end
    doneCount = 0;
    enSeen = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) doneCount++;
      if (motor_en || busy) enSeen++;
    end
    checks++;
    if (doneCount != 0 || enSeen != 0 || riseQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_quiet: extra done %0d en/busy %0d pulses %0d expected 0 0 0",
               doneCount, enSeen, riseQ.size());
    end
  endtask

  task automatic test_ramp_ten(output int doneCyc);
    int t;
    bit ok;
    int per[10] = '{1000, 900, 800, 700, 700, 700, 700, 800, 900, 1000};
    clear_q();
    send_cmd(10, 1'b0, 700, t, ok);
    checks++;
    if (!ok || vref_level !== 4'd15 || dir !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ten_setup: vref %0d dir %b expected 15 0", vref_level, dir);
    end
    wait_done(12000, ok);
    doneCyc = cyc;
    checks++;
    if (!ok || riseQ.size() != 10) begin
      errors++;
      $display("[TB] FAIL ten_count: got %0d expected 10", riseQ.size());
    end else begin
      checks++;
      if (riseQ[0] != t + 21) begin
        errors++;
        $display("[TB] FAIL ten_first: got %0d expected 21", riseQ[0] - t);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (riseQ[i + 1] - riseQ[i] != per[i]) begin
          errors++;
          $display("[TB] FAIL ten_period%0d: got %0d expected %0d", i, riseQ[i + 1] - riseQ[i], per[i]);
        end
      end
      checks++;
      if (doneCyc - riseQ[9] != per[9]) begin
        errors++;
        $display("[TB] FAIL ten_last: got %0d expected %0d", doneCyc - riseQ[9], per[9]);
      end
    end
    checks++;
    if (vref_level !== 4'd4 || steps_left !== '0 || aborted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ten_hold: vref %0d steps_left %0d aborted %b expected 4 0 0", vref_level, steps_left, aborted);
    end
`ifdef STEPPER_POSITION_EN
    checks++;
    if (position !== -32'sd7) begin errors++; $display("[TB] FAIL ten_pos: got %0d expected -7", position); end
`endif
  endtask

  task automatic test_hold_reentry(output int doneCyc);
    int t;
    bit ok;
    int falls0;
    repeat (98) @(negedge clk);
    falls0 = enFalls;
    checks++;
    if (dir !== 1'b0 || motor_en !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reentry_pre: dir %b en %b ready %b expected 0 1 1", dir, motor_en, cmd_ready);
    end
    clear_q();
    send_cmd(4, 1'b1, 700, t, ok);
    checks++;
    if (!ok || dir !== 1'b1 || busy !== 1'b1 || vref_level !== 4'd15) begin
      errors++;
      $display("[TB] FAIL reentry_setup: dir %b busy %b vref %0d expected 1 1 15", dir, busy, vref_level);
    end
    wait_done(6000, ok);
    doneCyc = cyc;
    checks++;
    if (enFalls != falls0) begin
      errors++;
      $display("[TB] FAIL reentry_en: got %0d drops expected 0", enFalls - falls0);
    end
    checks++;
    if (!ok || riseQ.size() != 4) begin
      errors++;
      $display("[TB] FAIL four_count: got %0d expected 4", riseQ.size());
    end else begin
      checks++;
      if (riseQ[0] != t + 21 || riseQ[1] - riseQ[0] != 1000 || riseQ[2] - riseQ[1] != 900 ||
          riseQ[3] - riseQ[2] != 1000 || doneCyc - riseQ[3] != 1000) begin
        errors++;
        $display("[TB] FAIL four_periods: got %0d %0d %0d %0d %0d expected 21 1000 900 1000 1000",
                 riseQ[0] - t, riseQ[1] - riseQ[0], riseQ[2] - riseQ[1], riseQ[3] - riseQ[2], doneCyc - riseQ[3]);
      end
    end
`ifdef STEPPER_POSITION_EN
    checks++;
    if (position !== -32'sd3) begin errors++; $display("[TB] FAIL four_pos: got %0d expected -3", position); end
`endif
  endtask

  task automatic test_abort;
    int t;
    bit ok;
    int dc;
    clear_q();
    send_cmd(10, 1'b0, 700, t, ok);
    while (cyc < t + 2726 && cyc < t + 5000) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(2000, ok);
    dc = cyc;
    checks++;
    if (!ok || dc != t + 3421) begin
      errors++;
      $display("[TB] FAIL abort_done: got cycle %0d expected 3421", dc - t);
    end
    checks++;
    if (aborted !== 1'b1 || steps_left !== 16'd6) begin
      errors++;
      $display("[TB] FAIL abort_flags: aborted %b steps_left %0d expected 1 6", aborted, steps_left);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (riseQ.size() != 4 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_edges: got %0d busy %b expected 4 0", riseQ.size(), busy);
    end
`ifdef STEPPER_POSITION_EN
    checks++;
    if (position !== -32'sd7) begin errors++; $display("[TB] FAIL abort_pos: got %0d expected -7", position); end
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    checks++;
    if (position !== 32'sd0) begin errors++; $display("[TB] FAIL pos_clear: got %0d expected 0", position); end
`endif
    wait_en_low(6000, ok);
    checks++;
    if (!ok || vref_level !== 4'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_idle: en %b vref %0d ready %b expected 0 0 1", motor_en, vref_level, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int t;
    bit ok;
    send_cmd(3, 1'b1, 1000, t, ok);
    while (cyc < t + 24) @(negedge clk);
    checks++;
    if (step_pulse !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_pre: pulse %b busy %b expected 1 1", step_pulse, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({step_pulse, dir, motor_en, busy, done, aborted} !== 6'b0 || vref_level !== 4'd0 || steps_left !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: ctrl %b vref %0d steps_left %0d expected 000000 0 0",
               {step_pulse, dir, motor_en, busy, done, aborted}, vref_level, steps_left);
    end
`ifdef STEPPER_POSITION_EN
    checks++;
    if (position !== 32'sd0) begin errors++; $display("[TB] FAIL midrun_pos: got %0d expected 0", position); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_ready: got %b expected 1", cmd_ready);
    end
    clear_q();
    repeat (60) @(negedge clk);
    checks++;
    if (riseQ.size() != 0 || motor_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_quiet: pulses %0d en %b expected 0 0", riseQ.size(), motor_en);
    end
  endtask

  initial begin
    int dcTen;
    int dcFour;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_dir    = 1'b0;
    cmd_period = '0;
    abort      = 1'b0;
`ifdef STEPPER_POSITION_EN
    pos_clear  = 1'b0;
`endif
    $display("[TB] starting stepper_move_sequencer bench");
    test_reset();
    test_three_steps();
    test_zero_steps();
    test_ramp_ten(dcTen);
    test_hold_reentry(dcFour);
    test_abort();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
